bf16_add_arb: RTL and testbench
===============================

# bf16_add_arb

Shares a single `bf16_add` instance between `NREQ` independent requesters. Each requester has its own valid/ready operand port and valid/ready result port. Arbitration is round-robin, with a 2-stage registered pipeline (operand register, result register), full one-op-per-cycle throughput and per-requester backpressure. It sits between the vector/accumulator front-ends and the combinational adder, and is the only block that drives the adder's inputs.

## Interface
- `NREQ`, default 4: number of requesters, range 2..16.
- `IDW`, default `$clog2(NREQ)`: requester index width (localparam).
- `clk`  in  1: clock, rising edge.
- `rst`  in  1: reset, asynchronous, active-high.
- `req_valid_i`  in  NREQ: requester i presents an operand pair.
- `req_ready_o`  out  NREQ: one-hot grant; the op is accepted when `req_valid_i[i] & req_ready_o[i]`.
- `req_a_i`  in  NREQ*16: operand a per requester as {s, e[7:0], m[6:0]}; requester i occupies bits [16i+15:16i].
- `req_b_i`  in  NREQ*16: operand b, same packing.
- `rsp_valid_o`  out  NREQ: one-hot; result available for requester i.
- `rsp_ready_i`  in  NREQ: requester i consumes the result.
- `rsp_data_o`  out  16: result {s, e, m}, shared bus, meaningful only while `|rsp_valid_o`.
- `busy_o`  out  1: any pipeline stage holds a valid op.

## Operation
- **Stage S1 registers.** `s1_v`, `s1_id`, `s1_a`, `s1_b`. These feed the `bf16_add` inputs directly.
- **Stage S2 registers.** `s2_v`, `s2_id`, `s2_r`, where `s2_r` is captured from the adder outputs.
- **Advance conditions.**
  - `adv2 = ~s2_v | rsp_ready_i[s2_id]`
  - `adv1 = ~s1_v | adv2`
- **Grant.**
  - When `adv1` is high, the round-robin arbiter grants exactly one requester with `req_valid_i` set.
  - Search order starts at `ptr` and wraps from NREQ-1 to 0.
  - When `adv1` is low, `req_ready_o` is all zero.
- **Pointer update.** On an accepted grant to requester g, `ptr <= (g+1) mod NREQ`. With no grant, `ptr` holds.
- **S1 load.** On `adv1`: `s1_v <= |grant`, `s1_id <= g`, and operands are loaded from slice g.
- **S2 load.** On `adv2`: `s2_v <= s1_v`, `s2_id <= s1_id`, `s2_r <= adder output`.
- **Response outputs.**
  - `rsp_valid_o = s2_v ? (1 << s2_id) : 0`.
  - `rsp_data_o = s2_r`.
- **Combinational paths.**
  - `req_ready_o` depends combinationally on `req_valid_i` and `rsp_ready_i`.
  - Requesters must not make `req_valid_i` depend on `req_ready_o`.
  - `rsp_valid_o` and `rsp_data_o` are driven from registers only.
- **Stability while stalled.** While stalled, S1 and S2 contents are stable, and `rsp_data_o` holds until consumed.
- **Requester-side contract** (the bench asserts these):
  - A requester holding valid keeps `req_a_i` and `req_b_i` stable until accepted.
  - Each requester receives its results in its own issue order.
- **Adder semantics are inherited from `bf16_add`.** Round toward zero, no NaN inputs. The sign is as produced by the adder; this block does not alter it.
- **`ptr` width.** `ptr` is IDW bits. When NREQ is not a power of two, it must never take values at or above NREQ.

## Timing
- **Reset values** (applied asynchronously while `rst` is high):
  - `s1_v = 0`, `s2_v = 0`, `ptr = 0`.
  - `s1_id`, `s2_id`, `s1_a`, `s1_b`, `s2_r` = 0.
  - Outputs therefore reset to `rsp_valid_o = 0`, `req_ready_o = 0`, `rsp_data_o = 0`, `busy_o = 0`.
- **Reset mid-operation.** All in-flight ops are dropped without a response. Acceptance resumes on the first edge after deassertion, with requester 0 at highest priority.
- **Latency.** An op accepted at edge T appears on `rsp_valid_o` after edge T+1, i.e. 2 cycles from acceptance to response valid. With no stall the response is consumed at edge T+2.
- **Throughput.** 1 op/cycle when the responder is always ready.
- **Full pipeline.** With `s2_v = 1` and the consumer not ready, S2 holds. If S1 is also valid, S1 holds and `req_ready_o = 0`.
- **Simultaneous drain and fill.** When `rsp_ready_i[s2_id]` is high in the same cycle, S2 takes S1 and S1 takes a new grant on the same edge, with no bubble.
- **Cross-requester head-of-line blocking is intentional.** A non-ready consumer stalls all requesters.
- **`busy_o`** is `s1_v | s2_v`, registered-derived.

## Structure
- **Package `bf16_pkg`:**
  - `localparam E = 8`, `M = 7`.
  - `typedef struct packed {logic s; logic [E-1:0] e; logic [M-1:0] m;} bf16_t`.
  - The NREQ maximum constant.
- **Sub-module `rr_arb`**, parameter N:
  - Inputs: `req[N]`, `ptr`, `en`.
  - Outputs: `gnt[N]` one-hot, `gnt_id`.
  - Purely combinational. `ptr` is owned by `bf16_add_arb`.
- **Adder instance:** one `bf16_add`, whose ports are mapped from `s1_a` and `s1_b`.

## Test plan
- **Single op:** after reset, req0 issues a=0x3F80 (1.0), b=0x3F80, with `rsp_ready_i` all 1 → `req_ready_o` = 0001 the same cycle; `rsp_valid_o` = 0001 with `rsp_data_o` = 0x4000 exactly 2 cycles later; `busy_o` high for those 2 cycles.
- **Round-robin:** all 4 requesters valid continuously, a=0x4000 (2.0), b=0x3F80 (1.0) → grant order 0,1,2,3,0,…; one response per cycle, each 0x4040 (3.0), with ids in the same order.
- **Backpressure:** hold `rsp_ready_i` = 0 for 5 cycles with req1 and req2 streaming → exactly 2 ops are in flight, `req_ready_o` = 0 during the stall, `rsp_data_o` is stable, and no op is lost or duplicated after release.
- **Pointer skip:** only req3 is valid, then only req1 → grants 3 then 1. `ptr` = 0 after the grant to 3, then `ptr` = 2.
- **Reset mid-flight:** assert `rst` for 1 cycle while `s1_v = s2_v = 1` → all outputs 0 immediately; no response is emitted for the dropped ops; the next grant goes to req0.
- **Random soak:** random valid/ready traffic, NREQ = 3 → the scoreboard sees per-requester order preserved, results equal to the `bf16_add` reference model, and `ptr` < 3 always.

Source files
------------

// File: rtl/bf16_pkg.sv
// Shared bf16 field layout and arbiter limits.
package bf16_pkg;
  localparam int E        = 8;
  localparam int M        = 7;
  localparam int NREQ_MAX = 16;

  localparam logic [15:0] BF16_QNAN    = 16'h7FC0;
  localparam logic [7:0]  EXP_INF      = 8'hFF;
  localparam logic [7:0]  EXP_MAX_FIN  = 8'hFE;

  typedef struct packed {
    logic         s;
    logic [E-1:0] e;
    logic [M-1:0] m;
  } bf16_t;
endpackage

// File: rtl/bf16_add.sv
// Combinational bf16 adder, round toward zero; subnormals handled, NaN inputs not expected.
module bf16_add
  import bf16_pkg::*;
(
  input  bf16_t a_i,
  input  bf16_t b_i,
  output bf16_t y_o
);

  logic        a_big;
  logic        sub;
  bf16_t       bg;
  bf16_t       sm;
  logic [7:0]  eb;
  logic [7:0]  es;
  logic [7:0]  d;
  logic [10:0] bg_x;
  logic [10:0] sm_x;
  logic [10:0] sh;
  logic [10:0] lost;
  logic [11:0] sum;
  logic [11:0] nrm;
  logic [3:0]  lead;
  logic [3:0]  lz;
  logic [8:0]  ex;

  always_comb begin
    a_big = {a_i.e, a_i.m} >= {b_i.e, b_i.m};
    bg    = a_big ? a_i : b_i;
    sm    = a_big ? b_i : a_i;
    sub   = a_i.s ^ b_i.s;
    eb    = (bg.e == '0) ? 8'd1 : bg.e;
    es    = (sm.e == '0) ? 8'd1 : sm.e;
    d     = eb - es;
    bg_x  = {(bg.e != '0), bg.m, 3'b000};
    sm_x  = {(sm.e != '0), sm.m, 3'b000};
    sh    = sm_x >> d;
    lost  = sm_x & ~(11'h7FF << d);
    // Subtracting the sticky bit keeps sum equal to the floor of the exact magnitude.
    if (sub) sum = {1'b0, bg_x} - {1'b0, sh} - {11'b0, (lost != '0)};
    else     sum = {1'b0, bg_x} + {1'b0, sh};

    lead = '0;
    for (int p = 0; p < 11; p++) begin
      if (sum[p]) lead = 4'(p);
    end
    lz = 4'd10 - lead;

    ex  = '0;
    nrm = '0;
    if (sum[11]) begin
      ex  = {1'b0, eb} + 9'd1;
      nrm = sum >> 1;
    end else if ({1'b0, eb} > {5'b0, lz}) begin
      ex  = {1'b0, eb} - {5'b0, lz};
      nrm = sum << lz;
    end else begin
      ex  = '0;
      nrm = sum << (eb - 8'd1);
    end

    y_o = '0;
    if (a_i.e == EXP_INF || b_i.e == EXP_INF) begin
      if (a_i.e == EXP_INF && b_i.e == EXP_INF && sub) y_o = BF16_QNAN;
      else if (a_i.e == EXP_INF)                      y_o = a_i;
      else                                            y_o = b_i;
    end else if (sum == '0) begin
      y_o.s = sub ? 1'b0 : bg.s;
    end else if (ex >= 9'd255) begin
      y_o = {bg.s, EXP_MAX_FIN, 7'h7F};
    end else begin
      y_o = {bg.s, ex[7:0], nrm[9:3]};
    end
  end

endmodule

// File: rtl/rr_arb.sv
// Combinational round-robin grant; search starts at ptr and wraps.
module rr_arb #(
  parameter int N   = 4,
  parameter int IDW = $clog2(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  input  logic           en,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] gnt_id
);

  logic found;
  int   idx;

  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    idx    = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (en && !found && req[idx]) begin
        gnt[idx] = 1'b1;
        gnt_id   = IDW'(idx);
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bf16_add_arb.sv
// Round-robin share of one bf16_add across NREQ requesters; 2-cycle latency, 1 op/cycle.
// A stalled response holds both stages and blocks every requester.
module bf16_add_arb
  import bf16_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid_i,
  output logic [NREQ-1:0]   req_ready_o,
  input  logic [NREQ*16-1:0] req_a_i,
  input  logic [NREQ*16-1:0] req_b_i,
  output logic [NREQ-1:0]   rsp_valid_o,
  input  logic [NREQ-1:0]   rsp_ready_i,
  output logic [15:0]       rsp_data_o,
  output logic              busy_o
);

  localparam int IDW = $clog2(NREQ);

  logic           s1_v_q, s1_v_d;
  logic [IDW-1:0] s1_id_q, s1_id_d;
  bf16_t          s1_a_q, s1_a_d;
  bf16_t          s1_b_q, s1_b_d;
  logic           s2_v_q, s2_v_d;
  logic [IDW-1:0] s2_id_q, s2_id_d;
  bf16_t          s2_r_q, s2_r_d;
  logic [IDW-1:0] ptr_q, ptr_d;

  logic            adv1, adv2;
  logic [NREQ-1:0] gnt;
  logic [IDW-1:0]  gnt_id;
  bf16_t           a_sel, b_sel;
  bf16_t           add_y;

  assign adv2 = ~s2_v_q | rsp_ready_i[s2_id_q];
  assign adv1 = ~s1_v_q | adv2;

  // Gating with rst keeps req_ready_o low while reset is held.
  rr_arb #(.N(NREQ), .IDW(IDW)) u_arb (
    .req    (req_valid_i),
    .ptr    (ptr_q),
    .en     (adv1 & ~rst),
    .gnt    (gnt),
    .gnt_id (gnt_id)
  );

  bf16_add u_add (
    .a_i (s1_a_q),
    .b_i (s1_b_q),
    .y_o (add_y)
  );

  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        a_sel = req_a_i[16*i +: 16];
        b_sel = req_b_i[16*i +: 16];
      end
    end
  end

  always_comb begin
    s1_v_d  = s1_v_q;
    s1_id_d = s1_id_q;
    s1_a_d  = s1_a_q;
    s1_b_d  = s1_b_q;
    s2_v_d  = s2_v_q;
    s2_id_d = s2_id_q;
    s2_r_d  = s2_r_q;
    ptr_d   = ptr_q;
    if (adv2) begin
      s2_v_d  = s1_v_q;
      s2_id_d = s1_id_q;
      s2_r_d  = add_y;
    end
    if (adv1) begin
      s1_v_d  = |gnt;
      s1_id_d = gnt_id;
      s1_a_d  = a_sel;
      s1_b_d  = b_sel;
    end
    if (|gnt) ptr_d = (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v_q  <= 1'b0;
      s1_id_q <= '0;
      s1_a_q  <= '0;
      s1_b_q  <= '0;
      s2_v_q  <= 1'b0;
      s2_id_q <= '0;
      s2_r_q  <= '0;
      ptr_q   <= '0;
    end else begin
      s1_v_q  <= s1_v_d;
      s1_id_q <= s1_id_d;
      s1_a_q  <= s1_a_d;
      s1_b_q  <= s1_b_d;
      s2_v_q  <= s2_v_d;
      s2_id_q <= s2_id_d;
      s2_r_q  <= s2_r_d;
      ptr_q   <= ptr_d;
    end
  end

  assign req_ready_o = gnt;
  assign rsp_valid_o = s2_v_q ? (NREQ'(1) << s2_id_q) : '0;
  assign rsp_data_o  = s2_r_q;
  assign busy_o      = s1_v_q | s2_v_q;

endmodule

// File: tb/tb_bf16_add_arb.sv
// Directed vectors and corner sequences on a 4-requester arbiter, random soak on a 3-requester one.
module tb_bf16_add_arb;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [3:0]  rv, rr, sv, sr;
  logic [63:0] ra, rb;
  logic [15:0] sd;
  logic        busy;

  bf16_add_arb #(.NREQ(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(rv), .req_ready_o(rr), .req_a_i(ra), .req_b_i(rb),
    .rsp_valid_o(sv), .rsp_ready_i(sr), .rsp_data_o(sd), .busy_o(busy)
  );

  logic [2:0]  rv3, rr3, sv3, sr3;
  logic [47:0] ra3, rb3;
  logic [15:0] sd3;
  logic        busy3;

  bf16_add_arb #(.NREQ(3)) dut3 (
    .clk(clk), .rst(rst),
    .req_valid_i(rv3), .req_ready_o(rr3), .req_a_i(ra3), .req_b_i(rb3),
    .rsp_valid_o(sv3), .rsp_ready_i(sr3), .rsp_data_o(sd3), .busy_o(busy3)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic real bf2r(input logic [15:0] x);
    logic [63:0] bits;
    if (x[14:7] == 8'd0) return 0.0;
    bits = {x[15], 11'(int'(x[14:7]) - 127 + 1023), x[6:0], 45'b0};
    return $bitstoreal(bits);
  endfunction

  // Exact in double for exponents within 120..135; truncating the mantissa gives round-toward-zero.
  function automatic logic [15:0] ref_add(input logic [15:0] a, input logic [15:0] b);
    real         s;
    logic [63:0] bits;
    int          e;
    s = bf2r(a) + bf2r(b);
    if (s == 0.0) return (a[15] & b[15]) ? 16'h8000 : 16'h0000;
    bits = $realtobits(s);
    e = int'(bits[62:52]) - 1023 + 127;
    return {bits[63], 8'(e), bits[51:45]};
  endfunction

  function automatic logic [15:0] rand_bf();
    return {1'($urandom_range(0, 1)), 8'($urandom_range(120, 135)), 7'($urandom_range(0, 127))};
  endfunction

  task automatic set_op(input int id, input logic [15:0] a, input logic [15:0] b);
    ra[16*id +: 16] = a;
    rb[16*id +: 16] = b;
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  typedef struct {
    int          id;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] y;
  } vec_t;

  vec_t tv[13];

  logic [15:0] exp_mem[3][16];
  int          wr[3];
  int          rd[3];
  logic [2:0]  acc3;

  initial begin
    tv[0]  = '{0, 16'h3F80, 16'h3F80, 16'h4000};
    tv[1]  = '{1, 16'h4000, 16'h3F80, 16'h4040};
    tv[2]  = '{2, 16'h3F80, 16'hBF80, 16'h0000};
    tv[3]  = '{3, 16'h4040, 16'hBF80, 16'h4000};
    tv[4]  = '{0, 16'h3F80, 16'h3B80, 16'h3F80};
    tv[5]  = '{1, 16'h3F80, 16'hBB00, 16'h3F7F};
    tv[6]  = '{2, 16'h7F7F, 16'h7F7F, 16'h7F7F};
    tv[7]  = '{3, 16'hC000, 16'h3F80, 16'hBF80};
    tv[8]  = '{0, 16'h0000, 16'h8000, 16'h0000};
    tv[9]  = '{1, 16'h8000, 16'h8000, 16'h8000};
    tv[10] = '{2, 16'h7F80, 16'h3F80, 16'h7F80};
    tv[11] = '{3, 16'h0001, 16'h0001, 16'h0002};
    tv[12] = '{0, 16'h4120, 16'h3F00, 16'h4128};

    rst = 1'b1; rv = '0; ra = '0; rb = '0; sr = '0;
    rv3 = '0; ra3 = '0; rb3 = '0; sr3 = '0;
    @(negedge clk); #1;
    chk("reset rsp_valid", 32'(sv), 32'h0);
    chk("reset req_ready", 32'(rr), 32'h0);
    chk("reset rsp_data", 32'(sd), 32'h0);
    chk("reset busy", 32'(busy), 32'h0);
    chk("reset ptr", 32'(dut.ptr_q), 32'h0);
    rst = 1'b0;
    sr  = 4'hF;

    for (int i = 0; i < 13; i++) begin
      rv = 4'(1 << tv[i].id);
      set_op(tv[i].id, tv[i].a, tv[i].b);
      #1 chk($sformatf("vec%0d ready", i), 32'(rr), 32'(1 << tv[i].id));
      @(negedge clk); rv = '0;
      #1 chk($sformatf("vec%0d s1 busy", i), {31'b0, busy}, 32'h1);
      chk($sformatf("vec%0d early rsp", i), 32'(sv), 32'h0);
      @(negedge clk); #1;
      chk($sformatf("vec%0d rsp_valid", i), 32'(sv), 32'(1 << tv[i].id));
      chk($sformatf("vec%0d rsp_data", i), 32'(sd), 32'(tv[i].y));
      chk($sformatf("vec%0d s2 busy", i), {31'b0, busy}, 32'h1);
      @(negedge clk); #1;
      chk($sformatf("vec%0d drained", i), {27'b0, sv, busy}, 32'h0);
    end

    // Round-robin with every requester valid
    pulse_rst();
    for (int i = 0; i < 4; i++) set_op(i, 16'h4000, 16'h3F80);
    rv = 4'hF;
    for (int k = 0; k < 10; k++) begin
      #1 chk($sformatf("rr grant k%0d", k), 32'(rr), 32'(1 << (k % 4)));
      if (k >= 2) begin
        chk($sformatf("rr rsp id k%0d", k), 32'(sv), 32'(1 << ((k - 2) % 4)));
        chk($sformatf("rr rsp data k%0d", k), 32'(sd), 32'h4040);
      end
      @(negedge clk);
    end
    rv = '0;
    repeat (3) @(negedge clk);

    // Backpressure: req1 and req2 stream while the consumer stalls
    pulse_rst();
    sr = '0;
    set_op(1, 16'h3F80, 16'h3F80);
    set_op(2, 16'h4000, 16'h3F80);
    rv = 4'b0110;
    #1 chk("bp grant1", 32'(rr), 32'h2);
    @(negedge clk);
    #1 chk("bp grant2", 32'(rr), 32'h4);
    @(negedge clk);
    for (int k = 2; k < 5; k++) begin
      #1 chk($sformatf("bp ready k%0d", k), 32'(rr), 32'h0);
      chk($sformatf("bp valid k%0d", k), 32'(sv), 32'h2);
      chk($sformatf("bp data k%0d", k), 32'(sd), 32'h4000);
      chk($sformatf("bp full k%0d", k), {30'b0, dut.s1_v_q, dut.s2_v_q}, 32'h3);
      @(negedge clk);
    end
    sr = 4'hF;
    for (int k = 0; k < 4; k++) begin
      #1 chk($sformatf("bp rel id k%0d", k), 32'(sv), (k % 2 == 0) ? 32'h2 : 32'h4);
      chk($sformatf("bp rel data k%0d", k), 32'(sd), (k % 2 == 0) ? 32'h4000 : 32'h4040);
      @(negedge clk);
    end
    rv = '0;
    repeat (3) @(negedge clk);
    #1 chk("bp idle", {31'b0, busy}, 32'h0);

    // Pointer skip
    pulse_rst();
    set_op(3, 16'h3F80, 16'h3F80);
    set_op(1, 16'h3F80, 16'h3F80);
    rv = 4'b1000;
    #1 chk("skip grant3", 32'(rr), 32'h8);
    @(negedge clk);
    chk("skip ptr after 3", 32'(dut.ptr_q), 32'h0);
    rv = 4'b0010;
    #1 chk("skip grant1", 32'(rr), 32'h2);
    @(negedge clk);
    chk("skip ptr after 1", 32'(dut.ptr_q), 32'h2);
    rv = '0;
    repeat (3) @(negedge clk);

    // Reset while both stages are full
    pulse_rst();
    sr = '0;
    set_op(0, 16'h3F80, 16'h3F80);
    rv = 4'b0001;
    @(negedge clk);
    @(negedge clk);
    #1 chk("midrst full", {30'b0, dut.s1_v_q, dut.s2_v_q}, 32'h3);
    chk("midrst rsp before", 32'(sv), 32'h1);
    rst = 1'b1;
    #1;
    chk("midrst rsp_valid", 32'(sv), 32'h0);
    chk("midrst req_ready", 32'(rr), 32'h0);
    chk("midrst busy", {31'b0, busy}, 32'h0);
    chk("midrst data", 32'(sd), 32'h0);
    @(negedge clk);
    rst = 1'b0; rv = '0; sr = 4'hF;
    #1 chk("midrst no rsp a", 32'(sv), 32'h0);
    @(negedge clk);
    #1 chk("midrst no rsp b", 32'(sv), 32'h0);
    for (int i = 0; i < 4; i++) set_op(i, 16'h3F80, 16'h3F80);
    rv = 4'hF;
    #1 chk("midrst first grant", 32'(rr), 32'h1);
    @(negedge clk);
    rv = '0;
    repeat (3) @(negedge clk);

    // Random soak on the 3-requester instance
    pulse_rst();
    for (int i = 0; i < 3; i++) begin wr[i] = 0; rd[i] = 0; end
    acc3 = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      int          id;
      logic [15:0] a, b;
      rv3 = rv3 & ~acc3;
      for (int i = 0; i < 3; i++) begin
        if (!rv3[i] && cyc < 2800 && $urandom_range(0, 2) == 0) begin
          a = rand_bf();
          b = rand_bf();
          ra3[16*i +: 16] = a;
          rb3[16*i +: 16] = b;
          rv3[i] = 1'b1;
        end
      end
      sr3 = (cyc < 2800) ? 3'($urandom) : 3'b111;
      #1;
      chk("soak ptr range", {31'b0, (dut3.ptr_q < 2'd3)}, 32'h1);
      chk("soak grant legal", {31'b0, ($onehot0(rr3) && ((rr3 & ~rv3) == 3'b0))}, 32'h1);
      if (|sv3) begin
        id = 0;
        for (int i = 0; i < 3; i++) if (sv3[i]) id = i;
        chk("soak rsp onehot", {31'b0, $onehot(sv3)}, 32'h1);
        if (sr3[id]) begin
          if (wr[id] == rd[id]) begin
            chk($sformatf("soak unexpected rsp req%0d", id), 32'(sd3), 32'hFFFF_FFFF);
          end else begin
            chk($sformatf("soak rsp req%0d", id), 32'(sd3), 32'(exp_mem[id][rd[id] % 16]));
            rd[id]++;
          end
        end
      end
      acc3 = rv3 & rr3;
      for (int i = 0; i < 3; i++) begin
        if (acc3[i]) begin
          exp_mem[i][wr[i] % 16] = ref_add(ra3[16*i +: 16], rb3[16*i +: 16]);
          wr[i]++;
        end
      end
      @(negedge clk);
    end
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("soak outstanding req%0d", i), 32'(wr[i] - rd[i]), 32'h0);
    end
    #1 chk("soak idle", {31'b0, busy3}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
